// File: rtl/bcd_conv_scheduler.sv
// Round-robin front end and shared 8-cycle double-dabble engine for up to four requesters.
// Define BCD_SCHED_HOLD_EN to keep each requester's last result on bcd_hold.
module bcd_conv_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] bin_in,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        valid,
  output logic [1:0]  valid_id,
  output logic [11:0] bcd_out,
  output logic [47:0] bcd_hold
);

  // state | meaning
  // IDLE  | arbiter live; grant, capture operand on any request
  // SHIFT | one add-3 / shift step per cycle; result on the 8th step
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [11:0] acc, acc_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [1:0]  last, last_nxt;
  logic [1:0]  id, id_nxt;
  logic [3:0]  gnt_nxt;
  logic        busy_nxt;
  logic        valid_nxt;
  logic [1:0]  valid_id_nxt;
  logic [11:0] bcd_nxt;

  logic        found;
  logic [1:0]  win;
  logic [1:0]  cand;
  logic [11:0] acc_adj;
  logic [11:0] acc_sh;
  logic [7:0]  shreg_sh;
  logic        done;

  function automatic logic [11:0] adj3(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int d = 0; d < 3; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Search starts one past the last winner, so last=3 favours requester 0.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign acc_adj  = adj3(acc);
  assign acc_sh   = {acc_adj[10:0], shreg[7]};
  assign shreg_sh = {shreg[6:0], 1'b0};
  assign done     = (state == SHIFT) && (cnt == 3'd7);

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    last_nxt     = last;
    id_nxt       = id;
    gnt_nxt      = 4'b0000;
    busy_nxt     = busy;
    valid_nxt    = 1'b0;
    valid_id_nxt = valid_id;
    bcd_nxt      = bcd_out;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (found) begin
          shreg_nxt     = bin_in[8*win +: 8];
          acc_nxt       = 12'h000;
          gnt_nxt       = 4'b0001 << win;
          last_nxt      = win;
          id_nxt        = win;
          cnt_nxt       = 3'd0;
          busy_nxt      = 1'b1;
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt   = acc_sh;
        shreg_nxt = shreg_sh;
        cnt_nxt   = cnt + 3'd1;
        if (done) begin
          bcd_nxt      = acc_sh;
          valid_id_nxt = id;
          valid_nxt    = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= 8'h00;
      acc      <= 12'h000;
      cnt      <= 3'd0;
      last     <= 2'd3;
      id       <= 2'd0;
      gnt      <= 4'b0000;
      busy     <= 1'b0;
      valid    <= 1'b0;
      valid_id <= 2'd0;
      bcd_out  <= 12'h000;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      id       <= id_nxt;
      gnt      <= gnt_nxt;
      busy     <= busy_nxt;
      valid    <= valid_nxt;
      valid_id <= valid_id_nxt;
      bcd_out  <= bcd_nxt;
    end
  end

`ifdef BCD_SCHED_HOLD_EN
  logic [47:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 48'h0;
    end else if (done) begin
      hold_q[12*id +: 12] <= acc_sh;
    end
  end

  assign bcd_hold = hold_q;
`else
  assign bcd_hold = 48'h0;
`endif

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler: conversions, arbitration order, reset abort, hold slots.
module tb_bcd_conv_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] bin_in;
  logic [3:0]  gnt;
  logic        busy;
  logic        valid;
  logic [1:0]  valid_id;
  logic [11:0] bcd_out;
  logic [47:0] bcd_hold;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bcd_conv_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .bin_in   (bin_in),
    .gnt      (gnt),
    .busy     (busy),
    .valid    (valid),
    .valid_id (valid_id),
    .bcd_out  (bcd_out),
    .bcd_hold (bcd_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        g = gnt;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic convert(input int r, input logic [7:0] v, input logic [11:0] expv, input string tag);
    logic [3:0] g;
    int lat;
    bin_in[8*r +: 8] = v;
    req[r] = 1'b1;
    wait_gnt(g);
    chk({tag, "_gnt"}, 48'(g), 48'(4'b0001 << r));
    req[r] = 1'b0;
    chk({tag, "_busy_hi"}, 48'(busy), 48'h1);
    wait_valid(lat);
    chk({tag, "_lat"}, 48'(lat), 48'd8);
    chk({tag, "_bcd"}, 48'(bcd_out), 48'(expv));
    chk({tag, "_id"}, 48'(valid_id), 48'(r));
    chk({tag, "_busy_lo"}, 48'(busy), 48'h0);
    @(negedge clk);
    chk({tag, "_vpulse"}, 48'(valid), 48'h0);
    chk({tag, "_bcd_held"}, 48'(bcd_out), 48'(expv));
  endtask

  logic [7:0]  sweep_in  [5] = '{8'd0, 8'd5, 8'd99, 8'd100, 8'd128};
  logic [11:0] sweep_exp [5] = '{12'h000, 12'h005, 12'h099, 12'h100, 12'h128};
  logic [11:0] sim_exp   [4] = '{12'h010, 12'h020, 12'h030, 12'h040};
  logic [3:0]  fair_exp  [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

  initial begin
    int ng, nv, tprev, lat, nvalid;
    logic [3:0] g;
    rst    = 1'b1;
    req    = 4'b0000;
    bin_in = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 48'(gnt), 48'h0);
    chk("rst_busy", 48'(busy), 48'h0);
    chk("rst_valid", 48'(valid), 48'h0);
    chk("rst_vid", 48'(valid_id), 48'h0);
    chk("rst_bcd", 48'(bcd_out), 48'h0);
    chk("rst_hold", bcd_hold, 48'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 48'(busy), 48'h0);

    convert(0, 8'd255, 12'h255, "single255");

    for (int k = 0; k < 5; k++) convert(2, sweep_in[k], sweep_exp[k], $sformatf("sweep%0d", k));

    // all four at once, each drops on its grant
    pulse_rst();
    bin_in = {8'd40, 8'd30, 8'd20, 8'd10};
    req    = 4'b1111;
    ng = 0; nv = 0; tprev = 0;
    for (int i = 0; i < 80 && nv < 4; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        chk($sformatf("sim_gnt%0d", ng), 48'(gnt), 48'(4'b0001 << ng));
        req = req & ~gnt;
        if (ng > 0) chk($sformatf("sim_space%0d", ng), 48'(cyc - tprev), 48'd9);
        tprev = cyc;
        ng++;
      end
      if (valid) begin
        chk($sformatf("sim_vid%0d", nv), 48'(valid_id), 48'(nv));
        chk($sformatf("sim_bcd%0d", nv), 48'(bcd_out), 48'(sim_exp[nv]));
        nv++;
      end
    end
    chk("sim_ngrants", 48'(ng), 48'd4);
    chk("sim_nvalids", 48'(nv), 48'd4);

    // fairness: 0 and 2 held high
    bin_in = {8'd0, 8'd7, 8'd0, 8'd3};
    req    = 4'b0101;
    ng = 0;
    for (int i = 0; i < 80 && ng < 4; i++) begin
      @(negedge clk);
      if (gnt != 4'b0000) begin
        chk($sformatf("fair_gnt%0d", ng), 48'(gnt), 48'(fair_exp[ng]));
        ng++;
        if (ng == 4) req = 4'b0000;
      end
    end
    chk("fair_ngrants", 48'(ng), 48'd4);
    wait_valid(lat);
    chk("fair_last_bcd", 48'(bcd_out), 48'h007);
    chk("fair_last_id", 48'(valid_id), 48'd2);

    // reset four cycles into a conversion
    bin_in[15:8] = 8'd77;
    req[1] = 1'b1;
    wait_gnt(g);
    chk("abort_gnt", 48'(g), 48'h2);
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bcd", 48'(bcd_out), 48'h0);
    chk("abort_busy", 48'(busy), 48'h0);
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    chk("abort_novalid", 48'(nvalid), 48'd0);
    bin_in = {8'd9, 8'd0, 8'd0, 8'd6};
    req = 4'b1001;
    wait_gnt(g);
    chk("abort_regrant", 48'(g), 48'h1);
    req = 4'b0000;
    wait_valid(lat);
    chk("abort_regrant_bcd", 48'(bcd_out), 48'h006);

    pulse_rst();
    chk("hold_cleared", bcd_hold, 48'h0);
    convert(1, 8'd42, 12'h042, "hold42");
    convert(3, 8'd200, 12'h200, "hold200");
`ifdef BCD_SCHED_HOLD_EN
    chk("hold_slots", bcd_hold, {12'h200, 12'h000, 12'h042, 12'h000});
`else
    chk("hold_slots", bcd_hold, 48'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
